ps_ddr_rd_ctrl: RTL and testbench
=================================

// Module: ps_ddr_rd_ctrl
// PURPOSE
//  Read-back engine for the PS DDR3 read window. Takes a command
//  (window offset + byte count), splits it into DDR read bursts
//  (ps_ddr_rd_start / addr / length), and buffers the returned words
//  (ps_ddr_rd_en / data) in an internal FIFO. Drains the FIFO to a
//  downstream consumer over a valid/ready stream.
//  Counterpart to the PS DDR write path; sits entirely in the ps_clk domain.
// PARAMETERS
//  BASE_ADDR    32'h3FF0_0000  first byte of the PS read window
//  WIN_BYTES    32'h0010_0000  window size in bytes; power of 2
//  BURST_BYTES  4096           max bytes per DDR read; multiple of 4, <=32768
//  FIFO_DEPTH   2048           FIFO depth in 32-bit words; >= 2*BURST_BYTES/4
// PORTS
//  ps_clk           in   1   clock (150 MHz)
//  ps_rst_n         in   1   reset, asynchronous, active-low
//  cmd_start        in   1   1-cycle pulse: accept a command (ignored while cmd_busy=1)
//  cmd_offset       in   32  byte offset in window; [1:0] ignored; taken modulo WIN_BYTES
//  cmd_bytes        in   32  total bytes to read; [1:0] ignored
//  cmd_busy         out  1   command in progress
//  cmd_done         out  1   1-cycle pulse: last burst finished
//  ps_ddr_busy      in   1   DDR port busy; sampled only before issuing a start
//  ps_ddr_rd_start  out  1   1-cycle read request
//  ps_ddr_rd_addr   out  32  burst start byte address
//  ps_ddr_rd_length out  32  burst length in bytes
//  ps_ddr_rd_data   in   32  returned data
//  ps_ddr_rd_en     in   1   returned data valid
//  ps_ddr_rd_finish in   1   1-cycle pulse: burst complete
//  dout             out  32  stream data
//  dout_valid       out  1   stream valid (FIFO not empty)
//  dout_ready       in   1   stream ready
//  err_overflow     out  1   sticky: rd_en arrived with FIFO full (word dropped)
//  err_len          out  1   sticky: words received != length/4 at finish
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0; FIFO emptied;
//  FSM=IDLE; sticky errors cleared.
//  FSM states:
//   IDLE: on cmd_start, latch addr=BASE_ADDR+(offset mod WIN), rem=bytes&~3.
//    rem==0 -> DONE (no DDR access); else -> PLAN. cmd_busy=1 in all non-IDLE states.
//   PLAN: len = min(rem, BURST_BYTES, BASE_ADDR+WIN_BYTES-addr). Go to ISSUE
//    when FIFO free words >= len/4 and ps_ddr_busy==0; otherwise hold.
//   ISSUE: rd_start=1 for exactly 1 cycle; rd_addr/rd_length registered,
//    stable from this cycle until rd_finish; -> WAIT_FIN.
//   WAIT_FIN: count rd_en words. On rd_finish: check the count (err_len);
//    rem-=len; addr+=len, wrapping to BASE_ADDR at the window end.
//    rem==0 -> DONE, else -> PLAN.
//   DONE: cmd_done=1 for 1 cycle; -> IDLE.
//  Ordering and timing:
//   rd_en and rd_finish in the same cycle: the word is accepted and counted.
//   cmd_done does not wait for the FIFO to drain.
//  FIFO: first-word fall-through.
//   Word written into an empty FIFO gives dout_valid=1 on the next cycle.
//   Transfer occurs when dout_valid & dout_ready; order is preserved.
//   Simultaneous write and read when full: the read frees the slot and the write is accepted.
//   Write when full with no read: word dropped, err_overflow=1 (unreachable given the PLAN space check).
//  Space reservation: free-word count = DEPTH - occupancy - words still outstanding in the current burst.
//  Reset mid-burst: immediate return to IDLE. Late rd_en/rd_finish arriving in IDLE are ignored.
// TESTING
//  1 offset=0, bytes=8192, ready=1 -> starts at 0x3FF00000/4096, then
//    0x3FF01000/4096; 2048 words out in order; one cmd_done.
//  2 offset=0xFF800, bytes=4096 -> 0x3FFFF800/2048, then 0x3FF00000/2048
//    (wrap); 1024 words out.
//  3 bytes=12288, dout_ready=0 -> 2 bursts fill 2048 words; 3rd start
//    withheld; raise ready -> 3rd issues after >=1024 words drain; err_overflow=0.
//  4 ps_ddr_busy=1 for 50 cycles at PLAN -> no start while busy; start 1 cycle
//    after busy falls.
//  5 bytes=0 (also bytes=3) -> no rd_start; cmd_done 2 cycles after cmd_start.
//  6 ps_rst_n low mid-burst -> all outputs 0, dout_valid=0; next cmd (test 1) passes.

Source files
------------

// File: rtl/ps_ddr_rd_ctrl.sv
// PS DDR3 read-back engine: splits a window read command into DDR bursts and
// buffers returned words in a first-word fall-through FIFO drained over valid/ready.
module ps_ddr_rd_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3FF0_0000,
  parameter logic [31:0] WIN_BYTES   = 32'h0010_0000,
  parameter int          BURST_BYTES = 4096,
  parameter int          FIFO_DEPTH  = 2048
) (
  input  logic        ps_clk,
  input  logic        ps_rst_n,
  input  logic        cmd_start,
  input  logic [31:0] cmd_offset,
  input  logic [31:0] cmd_bytes,
  output logic        cmd_busy,
  output logic        cmd_done,
  input  logic        ps_ddr_busy,
  output logic        ps_ddr_rd_start,
  output logic [31:0] ps_ddr_rd_addr,
  output logic [31:0] ps_ddr_rd_length,
  input  logic [31:0] ps_ddr_rd_data,
  input  logic        ps_ddr_rd_en,
  input  logic        ps_ddr_rd_finish,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        err_overflow,
  output logic        err_len
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] WIN_END   = BASE_ADDR + WIN_BYTES;
  localparam logic [31:0] BURST_MAX = 32'(BURST_BYTES);
  localparam logic [31:0] DEPTH_W   = 32'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAN,
    ST_ISSUE,
    ST_WAIT_FIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [31:0] addr_reg, rem_reg, len_reg, rd_addr_reg, rcv_cnt_reg;
  logic        cmd_done_reg, err_overflow_reg, err_len_reg;

  logic [31:0] cmd_rem, win_left, plan_len, burst_words, outstanding;
  logic [31:0] free_words, rcv_total, rem_after, addr_after;
  logic        space_ok;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [31:0]   rdata_reg, bypass_data_reg;
  logic          bypass_sel_reg, fifo_full, fifo_empty, wr_req, push, pop;

  always_comb begin
    cmd_rem  = cmd_bytes & ~32'd3;
    win_left = WIN_END - addr_reg;
    plan_len = rem_reg;
    if (plan_len > BURST_MAX) plan_len = BURST_MAX;
    if (plan_len > win_left)  plan_len = win_left;
    burst_words = len_reg >> 2;
    // Words of the in-flight burst not yet landed still own FIFO space.
    outstanding = (state_reg == ST_WAIT_FIN && rcv_cnt_reg < burst_words)
                  ? burst_words - rcv_cnt_reg : 32'd0;
    free_words = DEPTH_W - 32'(count_reg) - outstanding;
    space_ok   = free_words >= (plan_len >> 2);
    rcv_total  = rcv_cnt_reg + 32'(ps_ddr_rd_en);
    rem_after  = rem_reg - len_reg;
    addr_after = (addr_reg + len_reg == WIN_END) ? BASE_ADDR : addr_reg + len_reg;
  end

  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (cmd_start) state_next = (cmd_rem == 32'd0) ? ST_DONE : ST_PLAN;
      ST_PLAN:     if (space_ok && !ps_ddr_busy) state_next = ST_ISSUE;
      ST_ISSUE:    state_next = ST_WAIT_FIN;
      ST_WAIT_FIN: if (ps_ddr_rd_finish) state_next = (rem_after == 32'd0) ? ST_DONE : ST_PLAN;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_busy        = (state_reg != ST_IDLE);
    ps_ddr_rd_start = (state_reg == ST_ISSUE);
  end

  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) begin
      addr_reg         <= '0;
      rem_reg          <= '0;
      len_reg          <= '0;
      rd_addr_reg      <= '0;
      rcv_cnt_reg      <= '0;
      cmd_done_reg     <= 1'b0;
      err_overflow_reg <= 1'b0;
      err_len_reg      <= 1'b0;
    end else begin
      cmd_done_reg <= (state_reg == ST_DONE);
      if (state_reg == ST_IDLE && cmd_start) begin
        addr_reg <= BASE_ADDR + ((cmd_offset & (WIN_BYTES - 32'd1)) & ~32'd3);
        rem_reg  <= cmd_rem;
      end
      if (state_reg == ST_PLAN && state_next == ST_ISSUE) begin
        len_reg     <= plan_len;
        rd_addr_reg <= addr_reg;
        rcv_cnt_reg <= '0;
      end
      if (state_reg == ST_WAIT_FIN) begin
        if (ps_ddr_rd_en) rcv_cnt_reg <= rcv_total;
        if (ps_ddr_rd_finish) begin
          if (rcv_total != burst_words) err_len_reg <= 1'b1;
          rem_reg  <= rem_after;
          addr_reg <= addr_after;
        end
      end
      if (wr_req && fifo_full && !pop) err_overflow_reg <= 1'b1;
    end
  end

  assign cmd_done         = cmd_done_reg;
  assign ps_ddr_rd_addr   = rd_addr_reg;
  assign ps_ddr_rd_length = len_reg;
  assign err_overflow     = err_overflow_reg;
  assign err_len          = err_len_reg;

  always_comb begin
    fifo_full   = (count_reg == CW'(FIFO_DEPTH));
    fifo_empty  = (count_reg == '0);
    pop         = !fifo_empty && dout_ready;
    wr_req      = ps_ddr_rd_en && (state_reg == ST_WAIT_FIN);
    push        = wr_req && (!fifo_full || pop);
    rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  end

  // Read address is looked ahead so the registered RAM output already holds the head word.
  always_ff @(posedge ps_clk) begin
    if (push) mem[wr_ptr_reg] <= ps_ddr_rd_data;
    rdata_reg <= mem[rd_ptr_next];
  end

  // A write landing on the address being read returns stale RAM data; forward it instead.
  always_ff @(posedge ps_clk or negedge ps_rst_n) begin
    if (!ps_rst_n) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      bypass_data_reg <= '0;
      bypass_sel_reg  <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      bypass_sel_reg <= push && (wr_ptr_reg == rd_ptr_next);
      if (push) begin
        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
        bypass_data_reg <= ps_ddr_rd_data;
      end
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (!push && pop) count_reg <= count_reg - CW'(1);
    end
  end

  assign dout_valid = !fifo_empty;
  assign dout       = fifo_empty ? 32'd0 : (bypass_sel_reg ? bypass_data_reg : rdata_reg);

endmodule

// File: tb/tb_ps_ddr_rd_ctrl.sv
// Directed bench for ps_ddr_rd_ctrl: a DDR responder returns each word's byte
// address as data, so the stream is checked against the window address sequence.
module tb_ps_ddr_rd_ctrl;
  localparam logic [31:0] BASE = 32'h3FF0_0000;
  localparam logic [31:0] WIN  = 32'h0010_0000;

  logic        ps_clk = 1'b0;
  logic        ps_rst_n = 1'b0;
  logic        cmd_start = 1'b0;
  logic [31:0] cmd_offset = '0;
  logic [31:0] cmd_bytes = '0;
  logic        cmd_busy, cmd_done;
  logic        ps_ddr_busy = 1'b0;
  logic        ps_ddr_rd_start;
  logic [31:0] ps_ddr_rd_addr, ps_ddr_rd_length;
  logic [31:0] ps_ddr_rd_data = '0;
  logic        ps_ddr_rd_en = 1'b0;
  logic        ps_ddr_rd_finish = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        err_overflow, err_len;

  ps_ddr_rd_ctrl dut (
    .ps_clk(ps_clk), .ps_rst_n(ps_rst_n),
    .cmd_start(cmd_start), .cmd_offset(cmd_offset), .cmd_bytes(cmd_bytes),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .ps_ddr_busy(ps_ddr_busy), .ps_ddr_rd_start(ps_ddr_rd_start),
    .ps_ddr_rd_addr(ps_ddr_rd_addr), .ps_ddr_rd_length(ps_ddr_rd_length),
    .ps_ddr_rd_data(ps_ddr_rd_data), .ps_ddr_rd_en(ps_ddr_rd_en),
    .ps_ddr_rd_finish(ps_ddr_rd_finish),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_overflow(err_overflow), .err_len(err_len)
  );

  always #5 ps_clk = ~ps_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Monitor: logs bursts, counts pulses, checks every stream word.
  logic [31:0] log_addr[$];
  logic [31:0] log_len[$];
  int          log_drained[$];
  int          n_starts = 0, n_fins = 0, done_cnt = 0, exp_idx = 0;
  int          idx_base = 0;
  logic [31:0] exp_off = '0;
  logic [31:0] burst_addr = '0;

  always @(negedge ps_clk) begin
    if (ps_rst_n) begin
      if (ps_ddr_rd_start) begin
        n_starts++;
        log_addr.push_back(ps_ddr_rd_addr);
        log_len.push_back(ps_ddr_rd_length);
        log_drained.push_back(exp_idx - idx_base);
        burst_addr = ps_ddr_rd_addr;
      end
      if (ps_ddr_rd_finish && cmd_busy) begin
        n_fins++;
        check("rd_addr_stable", ps_ddr_rd_addr, burst_addr);
      end
      if (cmd_done) done_cnt++;
      if (dout_valid && dout_ready) begin
        check("dout_word", dout, BASE + ((exp_off + 32'(exp_idx - idx_base) * 32'd4) & (WIN - 32'd1)));
        exp_idx++;
      end
    end
  end

  // DDR responder: data = byte address; finish coincides with the last word.
  logic ddr_active = 1'b0;
  initial begin
    logic [31:0] a;
    int n;
    forever begin
      @(negedge ps_clk);
      if (ps_ddr_rd_start && ps_rst_n) begin
        a = ps_ddr_rd_addr;
        n = int'(ps_ddr_rd_length >> 2);
        ddr_active = 1'b1;
        @(posedge ps_clk);
        @(posedge ps_clk);
        #1;
        for (int i = 0; i < n; i++) begin
          ps_ddr_rd_data   = a + 32'(i) * 32'd4;
          ps_ddr_rd_en     = 1'b1;
          ps_ddr_rd_finish = (i == n - 1);
          @(posedge ps_clk);
          #1;
        end
        ps_ddr_rd_en     = 1'b0;
        ps_ddr_rd_finish = 1'b0;
        ps_ddr_rd_data   = '0;
        ddr_active       = 1'b0;
      end
    end
  end

  function automatic logic [31:0] la(input int k);
    return (log_addr.size() > k) ? log_addr[k] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] ll(input int k);
    return (log_len.size() > k) ? log_len[k] : 32'hDEAD_BEEF;
  endfunction
  function automatic int ld(input int k);
    return (log_drained.size() > k) ? log_drained[k] : -1;
  endfunction

  task automatic send_cmd(input logic [31:0] off, input logic [31:0] bytes);
    @(posedge ps_clk);
    #1;
    exp_off    = off;
    idx_base   = exp_idx;
    cmd_offset = off;
    cmd_bytes  = bytes;
    cmd_start  = 1'b1;
    @(posedge ps_clk);
    #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int c = 0;
    while (!cmd_done && c < max_cyc) begin
      @(negedge ps_clk);
      c++;
    end
    check({tag, "_done_in_time"}, 32'(c < max_cyc), 32'd1);
    c = 0;
    while (dout_valid && dout_ready && c < max_cyc) begin
      @(negedge ps_clk);
      c++;
    end
    check({tag, "_drained"}, 32'(dout_valid), 32'd0);
    repeat (5) @(negedge ps_clk);
  endtask

  task automatic run_test1(input string tag);
    int s0 = n_starts;
    int d0 = done_cnt;
    send_cmd(32'd0, 32'd8192);
    wait_done(tag, 6000);
    check({tag, "_starts"}, 32'(n_starts - s0), 32'd2);
    check({tag, "_addr0"}, la(s0), 32'h3FF0_0000);
    check({tag, "_len0"}, ll(s0), 32'd4096);
    check({tag, "_addr1"}, la(s0 + 1), 32'h3FF0_1000);
    check({tag, "_len1"}, ll(s0 + 1), 32'd4096);
    check({tag, "_words"}, 32'(exp_idx - idx_base), 32'd2048);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_err_len"}, 32'(err_len), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(cmd_busy), 32'd0);
    check({tag, "_done"}, 32'(cmd_done), 32'd0);
    check({tag, "_rd_start"}, 32'(ps_ddr_rd_start), 32'd0);
    check({tag, "_rd_addr"}, ps_ddr_rd_addr, 32'd0);
    check({tag, "_rd_len"}, ps_ddr_rd_length, 32'd0);
    check({tag, "_dout"}, dout, 32'd0);
    check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    check({tag, "_err_ovf"}, 32'(err_overflow), 32'd0);
    check({tag, "_err_len"}, 32'(err_len), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, f0, c;

    // Reset state
    repeat (3) @(negedge ps_clk);
    check_all_zero("reset");
    @(posedge ps_clk);
    #1;
    ps_rst_n = 1'b1;
    repeat (2) @(negedge ps_clk);

    // 1: two full bursts
    run_test1("t1");

    // 2: window wrap splits the request at the window end
    s0 = n_starts;
    send_cmd(32'h000F_F800, 32'd4096);
    wait_done("t2", 4000);
    check("t2_starts", 32'(n_starts - s0), 32'd2);
    check("t2_addr0", la(s0), 32'h3FFF_F800);
    check("t2_len0", ll(s0), 32'd2048);
    check("t2_addr1", la(s0 + 1), 32'h3FF0_0000);
    check("t2_len1", ll(s0 + 1), 32'd2048);
    check("t2_words", 32'(exp_idx - idx_base), 32'd1024);

    // 3: backpressure holds off the third burst until space is freed
    dout_ready = 1'b0;
    s0 = n_starts;
    f0 = n_fins;
    send_cmd(32'd0, 32'd12288);
    c = 0;
    while ((n_fins - f0) < 2 && c < 5000) begin
      @(negedge ps_clk);
      c++;
    end
    check("t3_two_bursts_in_time", 32'(c < 5000), 32'd1);
    repeat (50) @(negedge ps_clk);
    check("t3_starts_held", 32'(n_starts - s0), 32'd2);
    check("t3_fifo_full_valid", 32'(dout_valid), 32'd1);
    check("t3_busy_held", 32'(cmd_busy), 32'd1);
    @(posedge ps_clk);
    #1;
    dout_ready = 1'b1;
    wait_done("t3", 6000);
    check("t3_starts", 32'(n_starts - s0), 32'd3);
    check("t3_addr2", la(s0 + 2), 32'h3FF0_2000);
    check("t3_drained_before_start", 32'(ld(s0 + 2) >= 1024), 32'd1);
    check("t3_words", 32'(exp_idx - idx_base), 32'd3072);
    check("t3_err_ovf", 32'(err_overflow), 32'd0);

    // 4: DDR busy withholds the start
    ps_ddr_busy = 1'b1;
    s0 = n_starts;
    send_cmd(32'd0, 32'd4096);
    repeat (50) @(negedge ps_clk);
    check("t4_no_start_busy", 32'(n_starts - s0), 32'd0);
    check("t4_cmd_busy", 32'(cmd_busy), 32'd1);
    @(posedge ps_clk);
    #1;
    ps_ddr_busy = 1'b0;
    @(negedge ps_clk);
    check("t4_start_not_same_cycle", 32'(ps_ddr_rd_start), 32'd0);
    @(negedge ps_clk);
    check("t4_start_next_cycle", 32'(ps_ddr_rd_start), 32'd1);
    wait_done("t4", 3000);
    check("t4_words", 32'(exp_idx - idx_base), 32'd1024);

    // 5: zero-length commands (0 and 3 bytes)
    for (int k = 0; k < 2; k++) begin
      s0 = n_starts;
      d0 = done_cnt;
      send_cmd(32'd0, (k == 0) ? 32'd0 : 32'd3);
      @(negedge ps_clk);
      check("t5_busy", 32'(cmd_busy), 32'd1);
      check("t5_done_early", 32'(cmd_done), 32'd0);
      @(negedge ps_clk);
      check("t5_done", 32'(cmd_done), 32'd1);
      @(negedge ps_clk);
      check("t5_done_one_cycle", 32'(cmd_done), 32'd0);
      repeat (3) @(negedge ps_clk);
      check("t5_no_start", 32'(n_starts - s0), 32'd0);
      check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
    end

    // 6: reset mid-burst, late responses ignored, then a normal command
    s0 = n_starts;
    send_cmd(32'd0, 32'd8192);
    c = 0;
    while (n_starts == s0 && c < 200) begin
      @(negedge ps_clk);
      c++;
    end
    check("t6_started", 32'(c < 200), 32'd1);
    repeat (100) @(posedge ps_clk);
    #1;
    ps_rst_n = 1'b0;
    @(negedge ps_clk);
    check_all_zero("t6_rst");
    repeat (3) @(posedge ps_clk);
    #1;
    ps_rst_n = 1'b1;
    c = 0;
    while (ddr_active && c < 3000) begin
      @(negedge ps_clk);
      c++;
    end
    check("t6_ddr_idle", 32'(c < 3000), 32'd1);
    repeat (5) @(negedge ps_clk);
    check("t6_late_ignored_valid", 32'(dout_valid), 32'd0);
    check("t6_late_ignored_busy", 32'(cmd_busy), 32'd0);
    check("t6_late_err_len", 32'(err_len), 32'd0);
    run_test1("t6_t1");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
